// File: rtl/matmul_if.sv
// Operand/result bus and control handshake for the matrix-multiply sequencer.
// The master side is the requester and memories; the slave side is the sequencer.
interface matmul_if #(
  parameter int MAX_M  = 4,
  parameter int MAX_N  = 4,
  parameter int MAX_P  = 4,
  parameter int DATA_W = 8
);
  localparam int ACC_W = 2*DATA_W + $clog2(MAX_N);
  localparam int MW    = $clog2(MAX_M+1);
  localparam int NW    = $clog2(MAX_N+1);
  localparam int PW    = $clog2(MAX_P+1);
  localparam int AAW   = (MAX_M*MAX_N > 1) ? $clog2(MAX_M*MAX_N) : 1;
  localparam int BAW   = (MAX_N*MAX_P > 1) ? $clog2(MAX_N*MAX_P) : 1;
  localparam int CAW   = (MAX_M*MAX_P > 1) ? $clog2(MAX_M*MAX_P) : 1;

  logic              start;
  logic              abort;
  logic [MW-1:0]     m;
  logic [NW-1:0]     n;
  logic [PW-1:0]     p;
  logic              a_rd_en;
  logic              b_rd_en;
  logic [AAW-1:0]    a_addr;
  logic [BAW-1:0]    b_addr;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  logic              c_wr_en;
  logic [CAW-1:0]    c_addr;
  logic [ACC_W-1:0]  c_wdata;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, abort, m, n, p, a_rdata, b_rdata,
    input  a_rd_en, b_rd_en, a_addr, b_addr, c_wr_en, c_addr, c_wdata, busy, done, err
  );

  modport slave (
    input  start, abort, m, n, p, a_rdata, b_rdata,
    output a_rd_en, b_rd_en, a_addr, b_addr, c_wr_en, c_addr, c_wdata, busy, done, err
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences C = A*B over external single-port operand memories, one MAC per FETCH/ACC pair.
// Every strobe, address and status output is registered straight from the FSM.
module matmul_sequencer #(
  parameter int MAX_M  = 4,
  parameter int MAX_N  = 4,
  parameter int MAX_P  = 4,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  matmul_if.slave   bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(MAX_N);
  localparam int MW    = $clog2(MAX_M+1);
  localparam int NW    = $clog2(MAX_N+1);
  localparam int PW    = $clog2(MAX_P+1);
  localparam int AAW   = (MAX_M*MAX_N > 1) ? $clog2(MAX_M*MAX_N) : 1;
  localparam int BAW   = (MAX_N*MAX_P > 1) ? $clog2(MAX_N*MAX_P) : 1;
  localparam int CAW   = (MAX_M*MAX_P > 1) ? $clog2(MAX_M*MAX_P) : 1;

  localparam logic [MW-1:0] MAX_M_V = MW'(MAX_M);
  localparam logic [NW-1:0] MAX_N_V = NW'(MAX_N);
  localparam logic [PW-1:0] MAX_P_V = PW'(MAX_P);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [MW-1:0]     r_m;
  logic [NW-1:0]     r_n;
  logic [PW-1:0]     r_p;
  logic [MW-1:0]     r_i;
  logic [PW-1:0]     r_j;
  logic [NW-1:0]     r_k;
  logic [ACC_W-1:0]  r_acc;

  logic              r_a_rd_en;
  logic              r_b_rd_en;
  logic [AAW-1:0]    r_a_addr;
  logic [BAW-1:0]    r_b_addr;
  logic              r_c_wr_en;
  logic [CAW-1:0]    r_c_addr;
  logic [ACC_W-1:0]  r_c_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_dims_ok;
  logic              w_k_last;
  logic              w_j_last;
  logic              w_i_last;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [MW-1:0]     w_fi;
  logic [PW-1:0]     w_fj;
  logic [NW-1:0]     w_fk;
  logic [AAW-1:0]    w_a_addr_nxt;
  logic [BAW-1:0]    w_b_addr_nxt;
  logic [CAW-1:0]    w_c_addr_cur;

  assign w_dims_ok = (bus.m != '0) && (bus.m <= MAX_M_V) &&
                     (bus.n != '0) && (bus.n <= MAX_N_V) &&
                     (bus.p != '0) && (bus.p <= MAX_P_V);

  assign w_k_last  = (r_k == r_n - NW'(1));
  assign w_j_last  = (r_j == r_p - PW'(1));
  assign w_i_last  = (r_i == r_m - MW'(1));

  assign w_prod    = {{DATA_W{1'b0}}, bus.a_rdata} * {{DATA_W{1'b0}}, bus.b_rdata};
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);

  // Indices of the next FETCH, so operand addresses can be registered on entry to FETCH.
  always_comb begin
    w_fi = r_i;
    w_fj = r_j;
    w_fk = '0;
    case (r_state)
      S_ACC: w_fk = r_k + NW'(1);
      S_WRITE: begin
        if (w_j_last) begin
          w_fi = r_i + MW'(1);
          w_fj = '0;
        end else begin
          w_fj = r_j + PW'(1);
        end
      end
      default: begin
        w_fi = '0;
        w_fj = '0;
      end
    endcase
  end

  assign w_a_addr_nxt = AAW'(int'(w_fi) * MAX_N + int'(w_fk));
  assign w_b_addr_nxt = BAW'(int'(w_fk) * MAX_P + int'(w_fj));
  assign w_c_addr_cur = CAW'(int'(r_i) * MAX_P + int'(r_j));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_n       <= '0;
      r_p       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_a_rd_en <= 1'b0;
      r_b_rd_en <= 1'b0;
      r_a_addr  <= '0;
      r_b_addr  <= '0;
      r_c_wr_en <= 1'b0;
      r_c_addr  <= '0;
      r_c_wdata <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_a_rd_en <= 1'b0;
      r_b_rd_en <= 1'b0;
      r_c_wr_en <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;

      // Abort only matters while busy; any write already on the bus this cycle completes.
      if (r_busy && bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_i     <= '0;
        r_j     <= '0;
        r_k     <= '0;
        r_acc   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (w_dims_ok) begin
                r_m       <= bus.m;
                r_n       <= bus.n;
                r_p       <= bus.p;
                r_i       <= '0;
                r_j       <= '0;
                r_k       <= '0;
                r_acc     <= '0;
                r_a_addr  <= w_a_addr_nxt;
                r_b_addr  <= w_b_addr_nxt;
                r_a_rd_en <= 1'b1;
                r_b_rd_en <= 1'b1;
                r_busy    <= 1'b1;
                r_state   <= S_FETCH;
              end else begin
                r_err <= 1'b1;
              end
            end
          end

          S_FETCH: r_state <= S_ACC;

          S_ACC: begin
            r_acc <= w_acc_nxt;
            if (w_k_last) begin
              r_c_wr_en <= 1'b1;
              r_c_addr  <= w_c_addr_cur;
              r_c_wdata <= w_acc_nxt;
              r_state   <= S_WRITE;
            end else begin
              r_k       <= w_fk;
              r_a_addr  <= w_a_addr_nxt;
              r_b_addr  <= w_b_addr_nxt;
              r_a_rd_en <= 1'b1;
              r_b_rd_en <= 1'b1;
              r_state   <= S_FETCH;
            end
          end

          S_WRITE: begin
            r_acc <= '0;
            r_k   <= '0;
            if (w_i_last && w_j_last) begin
              r_i     <= '0;
              r_j     <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i       <= w_fi;
              r_j       <= w_fj;
              r_a_addr  <= w_a_addr_nxt;
              r_b_addr  <= w_b_addr_nxt;
              r_a_rd_en <= 1'b1;
              r_b_rd_en <= 1'b1;
              r_state   <= S_FETCH;
            end
          end

          S_DONE: r_state <= S_IDLE;

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.a_rd_en = r_a_rd_en;
  assign bus.b_rd_en = r_b_rd_en;
  assign bus.a_addr  = r_a_addr;
  assign bus.b_addr  = r_b_addr;
  assign bus.c_wr_en = r_c_wr_en;
  assign bus.c_addr  = r_c_addr;
  assign bus.c_wdata = r_c_wdata;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed and randomized checks of matmul_sequencer against a loop-based matrix product model.
module tb_matmul_sequencer;
  localparam int MM = 4;
  localparam int MN = 4;
  localparam int MP = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;

  matmul_if #(.MAX_M(MM), .MAX_N(MN), .MAX_P(MP), .DATA_W(DW)) bus();

  matmul_sequencer #(.MAX_M(MM), .MAX_N(MN), .MAX_P(MP), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem_a [MM*MN];
  logic [DW-1:0] mem_b [MN*MP];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  int wr_addr [$];
  int wr_data [$];
  int wr_cyc  [$];
  int rd_cnt, rd_pair_bad, busy_cnt, busy_first, done_cnt, done_cyc, err_cnt, err_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rdata <= mem_a[bus.a_addr];
    if (bus.b_rd_en) bus.b_rdata <= mem_b[bus.b_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.c_wr_en) begin
        wr_addr.push_back(int'(bus.c_addr));
        wr_data.push_back(int'(bus.c_wdata));
        wr_cyc.push_back(cyc - t0);
      end
      if (bus.a_rd_en) rd_cnt++;
      if (bus.a_rd_en != bus.b_rd_en) rd_pair_bad++;
      if (bus.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc - t0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (bus.err) begin
        err_cnt++;
        err_cyc = cyc - t0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no summary, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    rd_cnt = 0; rd_pair_bad = 0; busy_cnt = 0; busy_first = -1;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
  endtask

  task automatic fill_rand();
    for (int x = 0; x < MM*MN; x++) mem_a[x] = DW'($urandom_range(0, 255));
    for (int x = 0; x < MN*MP; x++) mem_b[x] = DW'($urandom_range(0, 255));
  endtask

  task automatic launch(input int m, input int n, input int p);
    clear_log();
    bus.m = 3'(m);
    bus.n = 3'(n);
    bus.p = 3'(p);
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) tick();
  endtask

  task automatic check_result(input string tag, input int m, input int n, input int p);
    int exp_addr [$];
    int exp_data [$];
    int per = 2*n + 1;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < p; j++) begin
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(mem_a[i*MN+k]) * int'(mem_b[k*MP+j]);
        exp_addr.push_back(i*MP + j);
        exp_data.push_back(s);
      end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, 1 + m*p*per);
    chk({tag, "_busy_cycles"}, busy_cnt, m*p*per);
    chk({tag, "_busy_first"}, busy_first, 1);
    chk({tag, "_rd_cnt"}, rd_cnt, m*p*n);
    chk({tag, "_rd_pair"}, rd_pair_bad, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_wr_cnt"}, wr_addr.size(), m*p);
    for (int e = 0; e < exp_addr.size(); e++) begin
      if (e < wr_addr.size()) begin
        chk($sformatf("%s_wr%0d_addr", tag, e), wr_addr[e], exp_addr[e]);
        chk($sformatf("%s_wr%0d_data", tag, e), wr_data[e], exp_data[e]);
        chk($sformatf("%s_wr%0d_cyc", tag, e), wr_cyc[e], 1 + e*per + 2*n);
      end
    end
  endtask

  task automatic run_op(input string tag, input int m, input int n, input int p);
    launch(m, n, p);
    wait_done(1 + m*p*(2*n+1) + 20);
    tick();
    tick();
    check_result(tag, m, n, p);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_strobes"}, int'({bus.a_rd_en, bus.b_rd_en, bus.c_wr_en, bus.busy, bus.done, bus.err}), 0);
    chk({tag, "_addr_data"}, int'(bus.a_addr) | int'(bus.b_addr) | int'(bus.c_addr) | int'(bus.c_wdata), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.m = '0; bus.n = '0; bus.p = '0;
    bus.a_rdata = '0; bus.b_rdata = '0;
    for (int x = 0; x < 16; x++) begin mem_a[x] = '0; mem_b[x] = '0; end
    clear_log();
    #3;
    chk_outputs_zero("reset_noclk");
    repeat (3) tick();
    chk_outputs_zero("reset_clk");
    rst = 1'b0;

    // 1x1x1, started on the first edge after reset release
    mem_a[0] = 8'd3;
    mem_b[0] = 8'd5;
    run_op("scalar", 1, 1, 1);

    // 2x2 times identity
    for (int x = 0; x < 16; x++) begin mem_a[x] = '0; mem_b[x] = '0; end
    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[MN] = 8'd3; mem_a[MN+1] = 8'd4;
    mem_b[0] = 8'd1; mem_b[MP+1] = 8'd1;
    run_op("ident", 2, 2, 2);

    // full size, all operands at max value
    for (int x = 0; x < 16; x++) begin mem_a[x] = 8'hFF; mem_b[x] = 8'hFF; end
    run_op("full255", 4, 4, 4);

    // invalid dimensions
    launch(2, 0, 2);
    repeat (4) tick();
    chk("err_n0_cnt", err_cnt, 1);
    chk("err_n0_cyc", err_cyc, 1);
    chk("err_n0_activity", rd_cnt + busy_cnt + done_cnt + wr_addr.size(), 0);
    launch(5, 2, 2);
    repeat (4) tick();
    chk("err_m5_cnt", err_cnt, 1);
    chk("err_m5_cyc", err_cyc, 1);
    chk("err_m5_activity", rd_cnt + busy_cnt + done_cnt + wr_addr.size(), 0);
    fill_rand();
    run_op("after_err", 2, 3, 2);

    // abort during the second ACC (cycle 4) of a 2x2x2 product
    fill_rand();
    launch(2, 2, 2);
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy_next", int'(bus.busy), 0);
    repeat (30) tick();
    chk("abort_rd_cnt", rd_cnt, 2);
    chk("abort_wr_cnt", wr_addr.size(), 0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_busy_cycles", busy_cnt, 4);
    fill_rand();
    run_op("after_abort", 2, 2, 2);

    // start held high while busy is ignored
    fill_rand();
    launch(2, 1, 2);
    bus.start = 1'b1;
    repeat (11) tick();
    bus.start = 1'b0;
    wait_done(40);
    repeat (6) tick();
    check_result("start_held", 2, 1, 2);

    // asynchronous reset in the middle of a 3x3x3 product
    fill_rand();
    launch(3, 3, 3);
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    chk_outputs_zero("reset_midop");
    repeat (3) tick();
    chk("reset_midop_done", done_cnt, 0);
    chk("reset_midop_wr_cnt", wr_addr.size(), 1);
    rst = 1'b0;
    fill_rand();
    run_op("after_reset", 3, 3, 3);

    // randomized dimensions and operands
    for (int r = 0; r < 6; r++) begin
      int m = $urandom_range(1, MM);
      int n = $urandom_range(1, MN);
      int p = $urandom_range(1, MP);
      fill_rand();
      run_op($sformatf("rand%0d", r), m, n, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
